i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
// Deserialises a standard I2S stream (lrclk=0 left, MSB one sclk after lrclk edge, sampled on sclk rise)
// into parallel 24-bit left/right words. Sits on the ADC/codec input side, feeding the effects chain;
// mirror of the transmitter. Runs entirely on mclk; sclk, lrclk and sdin are treated as async inputs.
// PARAMETERS
// DATA_WIDTH   24  bits captured per channel, MSB first
// SLOT_WIDTH   32  sclk periods per channel slot (half lrclk period)
// SYNC_STAGES  2   synchroniser flops on sclk, lrclk and sdin (>=2)
// PORTS
// mclk       in   1           system clock (>= 4x sclk)
// rst        in   1           asynchronous, active-low reset
// sclk       in   1           I2S bit clock, from i2s_clock_divider or external codec
// lrclk      in   1           I2S word select: 0 = left slot, 1 = right slot
// sdin       in   1           I2S serial data
// ldata      out  DATA_WIDTH  last complete left word
// rdata      out  DATA_WIDTH  last complete right word (same frame as ldata)
// valid      out  1           one-mclk pulse: ldata/rdata just updated
// frame_err  out  1           one-mclk pulse: malformed slot detected
// BEHAVIOUR
// - Reset (rst=0, async): ldata=0, rdata=0, valid=0, frame_err=0, state=HUNT, counters and shift reg cleared.
// - sclk/lrclk/sdin pass through SYNC_STAGES flops; sclk rise = (sclk_s & ~sclk_q) in mclk domain.
// - All protocol actions occur only on mclk cycles flagged as a sclk rise ("tick"); other cycles hold.
// - At each tick: sample lrclk_s, sdin_s; edge = lrclk_s != lrclk of previous tick.
// - One-bit delay: the tick that sees the edge carries the previous slot's LSB; bit_cnt reset to 0.
//   The next DATA_WIDTH ticks shift sdin into shreg MSB-first; ticks beyond DATA_WIDTH are ignored.
// - slot_cnt counts ticks since last edge (saturating at SLOT_WIDTH+1).
// - FSM states: HUNT, LEFT, RIGHT.
//   HUNT: wait for edge with lrclk_s=0 (1->0) -> LEFT. No outputs change.
//   LEFT: on edge 0->1: if bit_cnt>=DATA_WIDTH, latch shreg to lhold, -> RIGHT; else frame_err, -> HUNT.
//   RIGHT: on edge 1->0: if bit_cnt>=DATA_WIDTH, ldata<=lhold, rdata<=shreg, valid pulse, -> LEFT;
//          else frame_err, -> LEFT (new left slot starts cleanly, lhold discarded).
//   LEFT/RIGHT: slot_cnt reaching SLOT_WIDTH+1 without edge -> frame_err pulse (once), -> HUNT.
// - Short slots with bit_cnt>=DATA_WIDTH but slot_cnt<SLOT_WIDTH are accepted (no error).
// - ldata/rdata update together, never individually; held stable between valid pulses.
// - Latency: valid and new data appear on the mclk cycle after the tick detecting the right->left edge,
//   i.e. SYNC_STAGES+2 mclk after the physical sclk rise.
// - Both errors on the same tick: frame_err pulses once; no valid in that cycle.
// - Reset mid-frame: outputs clear immediately; first valid only after a complete left+right pair
//   following the first observed 1->0 lrclk edge.
// - valid and frame_err never asserted in the same cycle.
// TESTING
// 1 Loopback with i2s_clock_divider + i2s_transmitter: L=50321, R=2131 -> valid pulse, ldata=50321, rdata=2131.
// 2 Extremes: L=0, R=16777215 then L=16777215, R=0 -> exact words, one valid per frame, no frame_err.
// 3 Reset (rst=0) mid right slot -> ldata=rdata=0 at once; no valid for partial frame; next full
//   frame L=34245, R=12312 -> valid with those values.
// 4 Short slot: toggle lrclk after 10 sclk in left slot -> frame_err pulse, no valid; following good
//   frame L=9044432, R=0 decoded correctly.
// 5 Stuck lrclk: hold lrclk=1 for 40 sclk -> single frame_err pulse, HUNT; recovers on next 1->0 edge.

Source files
------------

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// Deserialises a standard I2S stream into parallel left/right words. The
// whole block runs on mclk; sclk, lrclk and sdin are asynchronous inputs that
// are resynchronised before use.
//
// Stream format: lrclk = 0 selects the left slot, lrclk = 1 the right slot.
// The MSB appears one sclk after each lrclk transition and data is sampled
// on the sclk rising edge. Up to DATA_WIDTH bits are kept per slot; any
// further bits in the slot are ignored.
//
// Ports
//   mclk       in   1           system clock (at least 4x sclk)
//   rst        in   1           asynchronous, active-low reset
//   sclk       in   1           I2S bit clock
//   lrclk      in   1           I2S word select (0 = left, 1 = right)
//   sdin       in   1           I2S serial data
//   ldata      out  DATA_WIDTH  last complete left word
//   rdata      out  DATA_WIDTH  last complete right word (same frame)
//   valid      out  1           one-mclk pulse: ldata/rdata just updated
//   frame_err  out  1           one-mclk pulse: malformed slot detected
//   fsm_state  out  2           debug view of the framing FSM
//                               (0 = HUNT, 1 = LEFT, 2 = RIGHT)
//
// Output semantics: valid is a pure strobe with no back-pressure. ldata and
// rdata change only in the cycle valid is high and are held otherwise.
// valid and frame_err are never high in the same cycle.
// ---------------------------------------------------------------------------
module i2s_receiver #(
    parameter int DATA_WIDTH  = 24,
    parameter int SLOT_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdin,
    output logic [DATA_WIDTH-1:0] ldata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  frame_err,
    output logic [1:0]            fsm_state
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam int SCW = $clog2(SLOT_WIDTH + 2);

    localparam logic [BCW-1:0] BIT_FULL  = BCW'(DATA_WIDTH);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_WIDTH);
    localparam logic [SCW-1:0] SLOT_SAT  = SCW'(SLOT_WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lrclk_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sclk_q;

    logic sclk_s;
    logic lrclk_s;
    logic sdin_s;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
    assign sdin_s  = sdin_sync[SYNC_STAGES-1];

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sclk_sync  <= '0;
            lrclk_sync <= '0;
            sdin_sync  <= '0;
            sclk_q     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
            sdin_sync  <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            sclk_q     <= sclk_s;
        end
    end

    // -----------------------------------------------------------------------
    // Tick stage: lrclk and sdin travel through synchronisers of the same
    // depth as sclk, so on the cycle a rising sclk edge is seen they still
    // hold the values present at that edge. Capture them with the tick so
    // the protocol logic works from one registered sample per bit.
    // -----------------------------------------------------------------------
    logic tick;
    logic lr_t;
    logic sd_t;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            tick <= 1'b0;
            lr_t <= 1'b0;
            sd_t <= 1'b0;
        end else begin
            tick <= sclk_s & ~sclk_q;
            if (sclk_s & ~sclk_q) begin
                lr_t <= lrclk_s;
                sd_t <= sdin_s;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slot datapath: previous lrclk, bit and slot counters, shift register
    // -----------------------------------------------------------------------
    logic                  prev_lr;
    logic [BCW-1:0]        bit_cnt;
    logic [SCW-1:0]        slot_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] lhold;

    logic lr_edge;
    logic slot_timeout;
    logic bit_full;

    assign lr_edge      = tick && (lr_t != prev_lr);
    // Fires on the tick that would take slot_cnt to SLOT_WIDTH+1; after that
    // the counter is saturated, so a stuck lrclk reports only once.
    assign slot_timeout = tick && !lr_edge && (slot_cnt == SLOT_LAST);
    assign bit_full     = (bit_cnt >= BIT_FULL);

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            prev_lr  <= 1'b0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            shreg    <= '0;
        end else if (tick) begin
            prev_lr <= lr_t;
            if (lr_edge) begin
                // The edge tick carries the previous slot's last bit; it is
                // not part of the new word.
                bit_cnt  <= '0;
                slot_cnt <= '0;
                shreg    <= '0;
            end else begin
                if (bit_cnt < BIT_FULL) begin
                    shreg   <= {shreg[DATA_WIDTH-2:0], sd_t};
                    bit_cnt <= bit_cnt + BCW'(1);
                end
                if (slot_cnt != SLOT_SAT) begin
                    slot_cnt <= slot_cnt + SCW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM: state register
    // -----------------------------------------------------------------------
    state_t state;
    state_t state_next;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    assign fsm_state = state;

    // -----------------------------------------------------------------------
    // Framing FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                // Only a right->left transition marks a usable frame start.
                if (lr_edge && !lr_t) begin
                    state_next = LEFT;
                end
            end
            LEFT: begin
                if (lr_edge) begin
                    state_next = bit_full ? RIGHT : HUNT;
                end else if (slot_timeout) begin
                    state_next = HUNT;
                end
            end
            RIGHT: begin
                // A short right slot still ends on a right->left edge, so the
                // new left slot can be used straight away.
                if (lr_edge) begin
                    state_next = LEFT;
                end else if (slot_timeout) begin
                    state_next = HUNT;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Framing FSM: outputs (one-cycle controls for the output registers)
    // -----------------------------------------------------------------------
    logic latch_left;
    logic commit;
    logic err;

    always_comb begin
        latch_left = 1'b0;
        commit     = 1'b0;
        err        = 1'b0;
        case (state)
            LEFT: begin
                if (lr_edge) begin
                    latch_left = bit_full;
                    err        = !bit_full;
                end else if (slot_timeout) begin
                    err = 1'b1;
                end
            end
            RIGHT: begin
                if (lr_edge) begin
                    commit = bit_full;
                    err    = !bit_full;
                end else if (slot_timeout) begin
                    err = 1'b1;
                end
            end
            default: begin
                latch_left = 1'b0;
                commit     = 1'b0;
                err        = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output registers. The left word waits in lhold until its right partner
    // arrives, so ldata and rdata always change together.
    // -----------------------------------------------------------------------
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            lhold     <= '0;
            ldata     <= '0;
            rdata     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= commit;
            frame_err <= err;
            if (latch_left) begin
                lhold <= shreg;
            end
            if (commit) begin
                ldata <= lhold;
                rdata <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Drives I2S slots into i2s_receiver and compares every decoded frame and
// every error pulse against a slot-level reference model. sclk runs at
// 1/6 of mclk; all stimulus changes happen away from mclk rising edges.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int DW = 24;
    localparam int SW = 32;

    logic          mclk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdin = 1'b0;
    logic [DW-1:0] ldata;
    logic [DW-1:0] rdata;
    logic          valid;
    logic          frame_err;
    logic [1:0]    fsm_state;

    i2s_receiver #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .SYNC_STAGES(2)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdin     (sdin),
        .ldata    (ldata),
        .rdata    (rdata),
        .valid    (valid),
        .frame_err(frame_err),
        .fsm_state(fsm_state)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    always #5 mclk = ~mclk;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Slot-level reference model. A slot of len sclk periods gives len-1
    // data ticks after its edge tick, so it holds a full word when
    // len >= DW+1. A slot of len >= SW+2 reaches SW+1 ticks without an edge.
    // Each slot is judged when the next slot starts.
    // -----------------------------------------------------------------------
    logic [47:0]   exp_q[$];
    int            exp_err = 0;
    int            m_mode  = 0;      // 0 hunting, 1 in left slot, 2 in right slot
    bit            m_prev_lr = 1'b0;
    bit            m_prev_ok = 1'b0;
    logic [DW-1:0] m_prev_word = '0;
    logic [DW-1:0] m_lhold = '0;

    function automatic void model_slot(input bit lr, input int len, input logic [DW-1:0] word);
        if (lr != m_prev_lr) begin
            case (m_mode)
                0: if (!lr) m_mode = 1;
                1: begin
                    if (m_prev_ok) begin
                        m_lhold = m_prev_word;
                        m_mode  = 2;
                    end else begin
                        exp_err++;
                        m_mode = 0;
                    end
                end
                default: begin
                    if (m_prev_ok) exp_q.push_back({m_lhold, m_prev_word});
                    else exp_err++;
                    m_mode = 1;
                end
            endcase
        end
        if (len >= SW + 2 && m_mode != 0) begin
            exp_err++;
            m_mode = 0;
        end
        m_prev_lr   = lr;
        m_prev_ok   = (len >= DW + 1);
        m_prev_word = word;
    endfunction

    function automatic void model_reset();
        m_mode    = 0;
        m_prev_lr = 1'b0;
        m_prev_ok = 1'b0;
    endfunction

    // -----------------------------------------------------------------------
    // Monitor: every valid must match the head of the expected queue and
    // arrive 4 mclk edges after the sclk rise that ended the frame.
    // -----------------------------------------------------------------------
    int          dut_err = 0;
    time         t_left_rise = 0;
    logic [47:0] got_pair;

    always @(negedge mclk) begin
        if (rst) begin
            if (valid && frame_err) check("valid_err_overlap", 48'd1, 48'd0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 48'd1, 48'd0);
                end else begin
                    got_pair = exp_q.pop_front();
                    check("ldata", 48'(ldata), 48'(got_pair[47:24]));
                    check("rdata", 48'(rdata), 48'(got_pair[23:0]));
                    check("latency", 48'($time - t_left_rise), 48'd40);
                end
            end
            if (frame_err) dut_err++;
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks. Data and lrclk change on sclk fall; sdin lags the
    // slot-aligned bit by one sclk, which gives the I2S one-bit delay.
    // -----------------------------------------------------------------------
    bit d_delay = 1'b0;

    task automatic sclk_cycle(input bit lr, input bit aligned, input bit mark);
        sclk    = 1'b0;
        lrclk   = lr;
        sdin    = d_delay;
        d_delay = aligned;
        #30;
        sclk = 1'b1;
        if (mark) t_left_rise = $time;
        #30;
    endtask

    task automatic send_slot(input bit lr, input int len, input logic [DW-1:0] word);
        bit b;
        model_slot(lr, len, word);
        for (int j = 0; j < len; j++) begin
            if (j < DW) b = word[DW-1-j];
            else b = 1'($urandom_range(0, 1));
            sclk_cycle(lr, b, (lr == 1'b0) && (j == 0));
        end
    endtask

    task automatic checkpoint(input string tag);
        #200;
        check({tag, "_errs"}, 48'(dut_err), 48'(exp_err));
        check({tag, "_pending"}, 48'(exp_q.size()), 48'd0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int kind;
        int len_l;
        int len_r;

        // Reset state
        #20;
        check("rst_ldata", 48'(ldata), 48'd0);
        check("rst_rdata", 48'(rdata), 48'd0);
        check("rst_valid", 48'(valid), 48'd0);
        check("rst_err", 48'(frame_err), 48'd0);
        check("rst_state", 48'(fsm_state), 48'd0);
        #20;
        rst = 1'b1;
        #20;

        // Lead-in right slot, then a basic frame
        send_slot(1'b1, 32, rand_word());
        send_slot(1'b0, 32, 24'd50321);
        send_slot(1'b1, 32, 24'd2131);

        // Extremes
        send_slot(1'b0, 32, 24'd0);
        #200;
        check("t1_ldata", 48'(ldata), 48'd50321);
        check("t1_rdata", 48'(rdata), 48'd2131);
        send_slot(1'b1, 32, 24'hFFFFFF);
        send_slot(1'b0, 32, 24'hFFFFFF);
        send_slot(1'b1, 32, 24'd0);
        checkpoint("extremes");

        // Reset in the middle of a right slot
        send_slot(1'b0, 32, rand_word());
        send_slot(1'b1, 16, rand_word());
        rst = 1'b0;
        #10;
        check("midrst_ldata", 48'(ldata), 48'd0);
        check("midrst_rdata", 48'(rdata), 48'd0);
        check("midrst_valid", 48'(valid), 48'd0);
        check("midrst_state", 48'(fsm_state), 48'd0);
        model_reset();
        #20;
        rst = 1'b1;
        #20;
        send_slot(1'b1, 16, rand_word());
        send_slot(1'b0, 32, 24'd34245);
        send_slot(1'b1, 32, 24'd12312);
        checkpoint("reset");

        // Short left slot, then a good frame
        send_slot(1'b0, 10, rand_word());
        #200;
        check("after_rst_ldata", 48'(ldata), 48'd34245);
        check("after_rst_rdata", 48'(rdata), 48'd12312);
        send_slot(1'b1, 32, rand_word());
        send_slot(1'b0, 32, 24'd9044432);
        send_slot(1'b1, 32, 24'd0);
        checkpoint("short");

        // Stuck lrclk high, then recovery
        send_slot(1'b0, 32, rand_word());
        #200;
        check("short_ldata", 48'(ldata), 48'd9044432);
        check("short_rdata", 48'(rdata), 48'd0);
        send_slot(1'b1, 40, rand_word());
        send_slot(1'b0, 32, rand_word());
        send_slot(1'b1, 32, rand_word());
        checkpoint("stuck");

        // Slot-length boundaries: 25 and 33 accepted, 24 short, 34 times out
        send_slot(1'b0, 25, rand_word());
        send_slot(1'b1, 33, rand_word());
        send_slot(1'b0, 24, rand_word());
        send_slot(1'b1, 32, rand_word());
        send_slot(1'b0, 34, rand_word());
        send_slot(1'b1, 32, rand_word());
        send_slot(1'b0, 32, rand_word());
        send_slot(1'b1, 32, rand_word());
        checkpoint("bounds");

        // Randomised frames with occasional malformed slots
        for (int f = 0; f < 30; f++) begin
            kind  = $urandom_range(0, 9);
            len_l = $urandom_range(DW + 1, SW + 1);
            len_r = $urandom_range(DW + 1, SW + 1);
            if (kind == 0) len_l = $urandom_range(8, DW);
            if (kind == 1) len_r = $urandom_range(SW + 2, SW + 8);
            if (kind == 2) len_r = $urandom_range(8, DW);
            send_slot(1'b0, len_l, rand_word());
            send_slot(1'b1, len_r, rand_word());
        end

        // Closing left slot lets the last right slot be judged
        send_slot(1'b0, 26, rand_word());
        checkpoint("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
